// File: rtl/jtag_uart_avalon_bridge.sv
// Avalon-MM master turning byte TX/RX streams into JTAG UART register traffic.
// Optional waitrequest stall timeout: define JTAG_UART_BRIDGE_TIMEOUT_EN.
module jtag_uart_avalon_bridge #(
    parameter int unsigned POLL_INTERVAL  = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        avm_chipselect,
    output logic        avm_address,
    output logic        avm_read_n,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        jtag_irq,
    input  logic        err_clear,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CTRL = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] poll_q, poll_d;
    logic [15:0] wspace_q, wspace_d;
    logic        rx_due_q, rx_due_d;
    logic        ctrl_due_q, ctrl_due_d;
    logic        ctrl_ok_q, ctrl_ok_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        cs_q, cs_d;
    logic        addr_q, addr_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [31:0] wdata_q, wdata_d;
    logic        tick;
    logic        done;
    logic        finish;

`ifdef JTAG_UART_BRIDGE_TIMEOUT_EN
    logic [31:0] stall_q, stall_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        wspace_d   = wspace_q;
        rx_due_d   = rx_due_q;
        ctrl_due_d = ctrl_due_q;
        ctrl_ok_d  = ctrl_ok_q;
        tx_full_d  = tx_full_q;
        tx_byte_d  = tx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        addr_d     = addr_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        wdata_d    = wdata_q;
        finish     = 1'b0;

        tick   = (poll_q == 16'(POLL_INTERVAL - 1));
        poll_d = tick ? 16'd0 : poll_q + 16'd1;
        done   = (state_q != IDLE) && !avm_waitrequest;

        if (tx_valid && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_byte_d = tx_data;
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (rx_due_q && !rx_valid_q) begin
                    state_d = RD_DATA;
                    cs_d    = 1'b1;
                    addr_d  = 1'b0;
                    rd_n_d  = 1'b0;
                end else if (tx_full_q && wspace_q != 16'd0) begin
                    state_d = WR_DATA;
                    cs_d    = 1'b1;
                    addr_d  = 1'b0;
                    wr_n_d  = 1'b0;
                    wdata_d = {24'h0, tx_byte_q};
                end else if (tx_full_q && (ctrl_due_q || ctrl_ok_q)) begin
                    state_d = RD_CTRL;
                    cs_d    = 1'b1;
                    addr_d  = 1'b1;
                    rd_n_d  = 1'b0;
                end
            end
            RD_CTRL: begin
                if (done) begin
                    wspace_d   = avm_readdata[31:16];
                    ctrl_due_d = 1'b0;
                    // A zero load blocks further reads until the next poll tick
                    ctrl_ok_d  = (avm_readdata[31:16] != 16'd0);
                end
            end
            WR_DATA: begin
                if (done) begin
                    tx_full_d = 1'b0;
                    wspace_d  = wspace_q - 16'd1;
                end
            end
            RD_DATA: begin
                if (done) begin
                    if (avm_readdata[15]) begin
                        rx_data_d  = avm_readdata[7:0];
                        rx_valid_d = 1'b1;
                    end
                    if (avm_readdata[31:16] == 16'd0) begin
                        rx_due_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        finish = done;

`ifdef JTAG_UART_BRIDGE_TIMEOUT_EN
        stall_d = 32'd0;
        err_d   = err_q;
        if (err_clear) begin
            err_d = 1'b0;
        end
        if (state_q != IDLE && avm_waitrequest) begin
            if (stall_q == 32'(TIMEOUT_CYCLES - 1)) begin
                finish = 1'b1;
                err_d  = 1'b1;
                if (state_q == WR_DATA) begin
                    tx_full_d = 1'b0;
                    wspace_d  = 16'd0;
                end
            end else begin
                stall_d = stall_q + 32'd1;
            end
        end
`endif

        if (finish) begin
            state_d = IDLE;
            cs_d    = 1'b0;
            addr_d  = 1'b0;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            wdata_d = 32'd0;
        end

        // Poll requests win over same-cycle clears
        if (tick || jtag_irq) begin
            rx_due_d = 1'b1;
        end
        if (tick) begin
            ctrl_due_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            poll_q     <= 16'd0;
            wspace_q   <= 16'd0;
            rx_due_q   <= 1'b0;
            ctrl_due_q <= 1'b0;
            ctrl_ok_q  <= 1'b1;
            tx_full_q  <= 1'b0;
            tx_byte_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            cs_q       <= 1'b0;
            addr_q     <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            poll_q     <= poll_d;
            wspace_q   <= wspace_d;
            rx_due_q   <= rx_due_d;
            ctrl_due_q <= ctrl_due_d;
            ctrl_ok_q  <= ctrl_ok_d;
            tx_full_q  <= tx_full_d;
            tx_byte_q  <= tx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef JTAG_UART_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign timeout_err = err_q;

    logic unused_bits;
    assign unused_bits = ^avm_readdata[14:8];
`else
    assign timeout_err = 1'b0;

    logic unused_bits;
    assign unused_bits = ^avm_readdata[14:8] ^ err_clear
                       ^ (TIMEOUT_CYCLES == 0);
`endif

    assign tx_ready       = ~tx_full_q;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;
    assign avm_chipselect = cs_q;
    assign avm_address    = addr_q;
    assign avm_read_n     = rd_n_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_jtag_uart_avalon_bridge.sv
// Bench for jtag_uart_avalon_bridge: Avalon slave model plus write/RX scoreboards.
// Timeout cases follow JTAG_UART_BRIDGE_TIMEOUT_EN as seen by the DUT build.
module tb_jtag_uart_avalon_bridge;

    localparam int PI = 32;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        avm_chipselect;
    logic        avm_address;
    logic        avm_read_n;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b1;
    logic        jtag_irq;
    logic        err_clear;
    logic        timeout_err;

    always #5 clk = ~clk;

    jtag_uart_avalon_bridge #(
        .POLL_INTERVAL (PI),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .avm_chipselect (avm_chipselect),
        .avm_address    (avm_address),
        .avm_read_n     (avm_read_n),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .jtag_irq       (jtag_irq),
        .err_clear      (err_clear),
        .timeout_err    (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_wr_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  src_q[$];
    logic [15:0] wspace_m = 16'd0;
    int stall_wr = 0;
    int stall_rd = 0;
    int scnt = 0;
    int n_ctrl = 0;
    int n_wr = 0;
    int n_drd = 0;
    int last_ctrl = 0;
    int prev_ctrl = 0;
    int last_wr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: decides waitrequest for the next edge and logs completions
    always @(posedge clk) begin
        logic [7:0] b;
        logic [7:0] e;
        #1;
        if (!reset_n || !avm_chipselect) begin
            avm_waitrequest = 1'b1;
            scnt = 0;
        end else if (scnt < (avm_write_n ? stall_rd : stall_wr)) begin
            avm_waitrequest = 1'b1;
            scnt++;
        end else begin
            avm_waitrequest = 1'b0;
            scnt = 0;
            if (!avm_write_n) begin
                n_wr++;
                last_wr = cyc;
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%0h", avm_writedata);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_data", avm_writedata, {24'h0, e});
                    chk("wr_addr", {31'd0, avm_address}, 32'd0);
                end
            end else if (avm_address) begin
                n_ctrl++;
                prev_ctrl = last_ctrl;
                last_ctrl = cyc;
                avm_readdata = {wspace_m, 16'h0};
            end else begin
                n_drd++;
                if (src_q.size() != 0) begin
                    b = src_q.pop_front();
                    avm_readdata = {16'(src_q.size()), 8'h80, b};
                end else begin
                    avm_readdata = 32'd0;
                end
            end
        end
    end

    // RX monitor: compare each byte the consumer takes
    always @(negedge clk) begin
        #2;
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h", rx_data);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
        end
    end

    task automatic check_reset(input string t);
        chk({t, "_cs"}, {31'd0, avm_chipselect}, 32'd0);
        chk({t, "_rd_n"}, {31'd0, avm_read_n}, 32'd1);
        chk({t, "_wr_n"}, {31'd0, avm_write_n}, 32'd1);
        chk({t, "_addr"}, {31'd0, avm_address}, 32'd0);
        chk({t, "_wdata"}, avm_writedata, 32'd0);
        chk({t, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({t, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({t, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({t, "_terr"}, {31'd0, timeout_err}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_wr);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, tx_ready}, 32'd1);
        if (expect_wr) exp_wr_q.push_back(b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int low;
        int lat;
        int b0c;
        int b0w;
        int w0;
        int d0;
        tx_data   = 8'd0;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        jtag_irq  = 1'b0;
        err_clear = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;

        // TX: first byte needs a control read, second uses the cache
        wspace_m = 16'd2;
        b0c = n_ctrl;
        b0w = n_wr;
        send(8'h41, 1'b1);
        k = 0;
        while (n_wr < b0w + 1 && k < 200) begin @(negedge clk); k++; end
        chk("wr1_count", n_wr, b0w + 1);
        chk("ctrl_before_wr", n_ctrl, b0c + 1);
        chk("ctrl_first", {31'd0, last_ctrl < last_wr}, 32'd1);
        send(8'h42, 1'b1);
        lat = 0;
        while (avm_write_n && lat < 10) begin @(negedge clk); lat++; end
        chk("tx_latency", {31'd0, lat <= 3}, 32'd1);
        k = 0;
        while (n_wr < b0w + 2 && k < 100) begin @(negedge clk); k++; end
        chk("wr2_count", n_wr, b0w + 2);
        chk("wr2_no_ctrl", n_ctrl, b0c + 1);

        // No write space: only tick-paced control reads
        wspace_m = 16'd0;
        send(8'h43, 1'b1);
        k = 0;
        while (n_ctrl < b0c + 5 && k < 250) begin @(negedge clk); k++; end
        chk("ctrl_polls", n_ctrl, b0c + 5);
        chk("wr_blocked", n_wr, b0w + 2);
        chk("tx_held", {31'd0, tx_ready}, 32'd0);
        chk("poll_gap", {31'd0, (last_ctrl - prev_ctrl >= PI - 1) &&
                               (last_ctrl - prev_ctrl <= PI + 1)}, 32'd1);
        wspace_m = 16'd1;
        k = 0;
        while (n_wr < b0w + 3 && k < 100) begin @(negedge clk); k++; end
        repeat (3 * PI) @(negedge clk);
        chk("one_wr", n_wr, b0w + 3);
        chk("tx_free", {31'd0, tx_ready}, 32'd1);

        // RX: irq-triggered poll, hold-off while full, back-to-back drain
        src_q = '{8'h55, 8'h66, 8'h77};
        exp_rx_q.push_back(8'h55);
        exp_rx_q.push_back(8'h66);
        exp_rx_q.push_back(8'h77);
        @(negedge clk);
        jtag_irq = 1'b1;
        @(negedge clk);
        jtag_irq = 1'b0;
        k = 0;
        while (!rx_valid && k < 50) begin @(negedge clk); k++; end
        chk("rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("rx_first", {24'd0, rx_data}, 32'h55);
        d0 = n_drd;
        repeat (500) @(negedge clk);
        chk("no_rd_when_full", n_drd, d0);
        chk("rx_kept", {24'd0, rx_data}, 32'h55);
        rx_ready = 1'b1;
        k = 0;
        while (n_drd == d0 && k < 10) begin @(negedge clk); k++; end
        chk("drain_latency", {31'd0, (k <= 2) && (n_drd > d0)}, 32'd1);
        k = 0;
        while (exp_rx_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chk("rx_drained", exp_rx_q.size(), 32'd0);
        @(negedge clk);
        rx_ready = 1'b0;

        // Stalled write: stable outputs, single completion
        wspace_m = 16'd4;
        stall_wr = 5;
        w0 = n_wr;
        send(8'h5A, 1'b1);
        k = 0;
        while (avm_write_n && k < 100) begin @(negedge clk); k++; end
        low = 0;
        while (!avm_write_n && low < 50) begin
            chk("wr_stable", {31'd0, avm_chipselect && !avm_address &&
                avm_read_n && avm_writedata == 32'h5A}, 32'd1);
            low++;
            @(negedge clk);
        end
        chk("wr_low_cycles", low, 32'd6);
        chk("tx_ready_after", {31'd0, tx_ready}, 32'd1);
        chk("wr_once", n_wr, w0 + 1);

        // Waitrequest stuck high
        stall_wr = 1_000_000;
        send(8'h77, 1'b0);
        k = 0;
        while (avm_write_n && k < 100) begin @(negedge clk); k++; end
        chk("stuck_started", {31'd0, avm_write_n}, 32'd0);
`ifdef JTAG_UART_BRIDGE_TIMEOUT_EN
        low = 0;
        while (!avm_write_n && low < 100) begin @(negedge clk); low++; end
        chk("to_cycles", low, TO);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("to_drop", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("to_clear", {31'd0, timeout_err}, 32'd0);
        send(8'h78, 1'b0);
        k = 0;
        while (avm_write_n && k < 200) begin @(negedge clk); k++; end
        chk("stuck2_started", {31'd0, avm_write_n}, 32'd0);
`else
        repeat (100) @(negedge clk);
        chk("hold_wr_n", {31'd0, avm_write_n}, 32'd0);
        chk("hold_cs", {31'd0, avm_chipselect}, 32'd1);
        chk("hold_no_terr", {31'd0, timeout_err}, 32'd0);
        chk("hold_full", {31'd0, tx_ready}, 32'd0);
`endif

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("arst_wr_n", {31'd0, avm_write_n}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset("post");

        chk("wr_sb_empty", exp_wr_q.size(), 32'd0);
        chk("rx_sb_empty", exp_rx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
